// File: rtl/ioctl_loader_pkg.sv
// ioctl_loader_pkg
// Shared types and constants for the ioctl boot-image RAM loader.
//   state_e    : loader session state (IDLE, LOAD, FLUSH)
//   BYTE_W     : width of one ioctl byte lane
//   PAD_BYTE   : fill value for lanes not covered by a short final word
//   CHECKSUM_W : width of the running byte checksum
package ioctl_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] PAD_BYTE = 8'hFF;
  localparam int CHECKSUM_W = 16;

  // Number of byte lanes in a RAM word.
  function automatic int lanes_per_word(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/ioctl_ram_loader_byte_packer.sv
// byte_packer
// Assembles little-endian RAM words from a byte stream.
//   clock, reset : clock and synchronous active-high reset
//   clear_i      : drop any partially assembled word
//   accept_i     : byte_i is taken into the current lane this cycle
//   byte_i       : incoming byte
//   word_done_o  : this accepted byte fills the top lane (word_o is complete)
//   word_o       : current shift contents with byte_i merged into its lane
//   partial_o    : at least one lane holds a byte of an unfinished word
//   pad_word_o   : unfinished word with the unfilled lanes set to PAD_BYTE
module byte_packer
  import ioctl_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  accept_i,
  input  logic [BYTE_W-1:0]     byte_i,
  output logic                  word_done_o,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  partial_o,
  output logic [DATA_WIDTH-1:0] pad_word_o
);

  localparam int BYTES = lanes_per_word(DATA_WIDTH);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  last_lane;

  assign last_lane   = (idx_q == IDX_W'(BYTES - 1));
  assign word_done_o = accept_i && last_lane;
  assign partial_o   = (idx_q != '0);

  always_comb begin
    word_o     = shift_q;
    pad_word_o = shift_q;
    for (int l = 0; l < BYTES; l++) begin
      if (idx_q == IDX_W'(l)) begin
        word_o[l*BYTE_W +: BYTE_W] = byte_i;
      end
      // Lanes at or above the index have not been written yet.
      if (l >= int'(idx_q)) begin
        pad_word_o[l*BYTE_W +: BYTE_W] = PAD_BYTE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (accept_i) begin
      if (last_lane) begin
        idx_q   <= '0;
        shift_q <= '0;
      end else begin
        idx_q   <= idx_q + IDX_W'(1);
        shift_q <= word_o;
      end
    end
  end

endmodule

// File: rtl/ioctl_ram_loader.sv
// ioctl_ram_loader
// Streams a boot image from the ioctl byte interface into a single-port RAM,
// packing bytes into words written at consecutive addresses from 0. While
// idle, the CPU port is passed straight through to the RAM.
//   clock, reset            : clock and synchronous active-high reset
//   ioctl_download          : high for the whole load session
//   ioctl_wr, ioctl_dout    : one-cycle byte strobe and its data
//   cpu_cs, cpu_wren,
//   cpu_address, cpu_data   : CPU-side RAM request
//   cpu_q                   : CPU read data (all ones while loading)
//   ram_cs, ram_wren,
//   ram_address, ram_data   : RAM port drive
//   ram_q                   : RAM read data
//   loading                 : session in progress (LOAD or FLUSH)
//   load_done               : one-cycle pulse after the session closes
//   word_count              : words written this session
//   checksum                : sum of accepted bytes modulo 2^16
//   overflow                : sticky, bytes beyond RAM capacity were dropped
module ioctl_ram_loader
  import ioctl_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [BYTE_W-1:0]     ioctl_dout,
  input  logic                  cpu_cs,
  input  logic                  cpu_wren,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  output logic [DATA_WIDTH-1:0] cpu_q,
  output logic                  ram_cs,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  loading,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [CHECKSUM_W-1:0] checksum,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                  state_q;
  logic                    wr_pend_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic [ADDR_WIDTH:0]     word_count_q;
  logic [CHECKSUM_W-1:0]   checksum_q;
  logic                    overflow_q;
  logic                    load_done_q;

  logic [ADDR_WIDTH:0]     committed;
  logic                    room;
  logic                    accept;
  logic                    pk_clear;
  logic                    pk_done;
  logic                    pk_partial;
  logic [DATA_WIDTH-1:0]   pk_word;
  logic [DATA_WIDTH-1:0]   pk_pad_word;
  logic                    flush_write;

  // A word waiting in the write register already owns its address, so it
  // counts against capacity even though word_count has not advanced yet.
  assign committed   = word_count_q + {{ADDR_WIDTH{1'b0}}, wr_pend_q};
  assign room        = (committed < CAPACITY);
  assign accept      = (state_q == LOAD) && ioctl_wr && room;
  assign pk_clear    = (state_q != LOAD);
  // A word completed in the last LOAD cycle leaves no partial lanes, so the
  // pad write and the pending write never coincide.
  assign flush_write = (state_q == FLUSH) && pk_partial && !wr_pend_q &&
                       (word_count_q < CAPACITY);

  byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (pk_clear),
    .accept_i    (accept),
    .byte_i      (ioctl_dout),
    .word_done_o (pk_done),
    .word_o      (pk_word),
    .partial_o   (pk_partial),
    .pad_word_o  (pk_pad_word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_pend_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      word_count_q <= '0;
      checksum_q   <= '0;
      overflow_q   <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      wr_pend_q   <= 1'b0;
      if (wr_pend_q || flush_write) begin
        word_count_q <= word_count_q + (ADDR_WIDTH+1)'(1);
      end
      case (state_q)
        IDLE: begin
          if (ioctl_download) begin
            state_q      <= LOAD;
            word_count_q <= '0;
            checksum_q   <= '0;
            overflow_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (ioctl_wr) begin
            if (room) begin
              checksum_q <= checksum_q + CHECKSUM_W'(ioctl_dout);
            end else begin
              overflow_q <= 1'b1;
            end
          end
          if (pk_done) begin
            wr_pend_q <= 1'b1;
            wr_addr_q <= committed[ADDR_WIDTH-1:0];
            wr_data_q <= pk_word;
          end
          if (!ioctl_download) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (pk_partial && !flush_write) begin
            overflow_q <= 1'b1;
          end
          load_done_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_cs      = 1'b0;
    ram_wren    = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    if (state_q == IDLE) begin
      ram_cs      = cpu_cs;
      ram_wren    = cpu_wren;
      ram_address = cpu_address;
      ram_data    = cpu_data;
    end else if (wr_pend_q) begin
      ram_cs      = 1'b1;
      ram_wren    = 1'b1;
      ram_address = wr_addr_q;
      ram_data    = wr_data_q;
    end else if (flush_write) begin
      ram_cs      = 1'b1;
      ram_wren    = 1'b1;
      ram_address = word_count_q[ADDR_WIDTH-1:0];
      ram_data    = pk_pad_word;
    end
  end

  assign cpu_q      = (state_q == IDLE) ? ram_q : '1;
  assign loading    = (state_q != IDLE);
  assign load_done  = load_done_q;
  assign word_count = word_count_q;
  assign checksum   = checksum_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ioctl_ram_loader.sv
module tb_ioctl_ram_loader;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int CAP_BYTES = (1 << AW) * (DW / 8);

  logic          clock = 1'b0;
  logic          reset;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [7:0]    ioctl_dout;
  logic          cpu_cs;
  logic          cpu_wren;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_data;
  logic [DW-1:0] cpu_q;
  logic          ram_cs;
  logic          ram_wren;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;
  logic          loading;
  logic          load_done;
  logic [AW:0]   word_count;
  logic [15:0]   checksum;
  logic          overflow;

  ioctl_ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock          (clock),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .cpu_cs         (cpu_cs),
    .cpu_wren       (cpu_wren),
    .cpu_address    (cpu_address),
    .cpu_data       (cpu_data),
    .cpu_q          (cpu_q),
    .ram_cs         (ram_cs),
    .ram_wren       (ram_wren),
    .ram_address    (ram_address),
    .ram_data       (ram_data),
    .ram_q          (ram_q),
    .loading        (loading),
    .load_done      (load_done),
    .word_count     (word_count),
    .checksum       (checksum),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  // Behavioural single-port RAM with registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (ram_cs && ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [7:0]    stim_b[$];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  logic [15:0]   exp_cs;
  int            exp_wc;
  bit            exp_ov;
  int            checks = 0;
  int            failures = 0;
  int            ld_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every RAM write must match the next expected write.
  always @(negedge clock) begin
    if (load_done) ld_cnt++;
    if (ram_cs && ram_wren) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr %h data %h, no write expected", ram_address, ram_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ram_write", 32'({ram_address, ram_data}), 32'({mon_e.addr, mon_e.data}));
      end
    end
  end

  // Reference: accepted bytes fill words little-endian from address 0,
  // capped at RAM capacity, short last word padded with FF.
  task automatic model_session(input int n);
    int acc;
    logic [DW-1:0] w;
    acc = (n > CAP_BYTES) ? CAP_BYTES : n;
    exp_cs = '0;
    for (int i = 0; i < acc; i++) exp_cs = exp_cs + 16'(stim_b[i]);
    exp_wc = (acc + 1) / 2;
    exp_ov = (n > CAP_BYTES);
    for (int k = 0; k < exp_wc; k++) begin
      w[7:0]  = stim_b[2*k];
      w[15:8] = (2*k + 1 < acc) ? stim_b[2*k+1] : 8'hFF;
      exp_q.push_back('{addr: AW'(k), data: w});
      exp_mem[k] = w;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (loading && k < 20) begin
      tick();
      k++;
    end
    if (loading) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: loading still %0d after 20 cycles, required 0", name, loading);
    end
  endtask

  task automatic run_session(input string name, input bit coincident, input bit gaps);
    int n;
    int ld0;
    n = stim_b.size();
    model_session(n);
    ld0 = ld_cnt;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          ioctl_wr = 1'b0;
          tick();
        end
      end
      ioctl_wr   = 1'b1;
      ioctl_dout = stim_b[i];
      if (coincident && i == n - 1) ioctl_download = 1'b0;
      tick();
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    wait_idle(name);
    tick();
    chk({name, "_word_count"}, 32'(word_count), 32'(exp_wc));
    chk({name, "_checksum"}, 32'(checksum), 32'(exp_cs));
    chk({name, "_overflow"}, 32'(overflow), 32'(exp_ov));
    chk({name, "_load_done"}, 32'(ld_cnt - ld0), 32'd1);
    chk({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    cpu_cs = 1'b1;
    cpu_wren = 1'b0;
    cpu_address = a;
    tick();
    d = cpu_q;
    cpu_cs = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] rd;
    int ld0;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_dout = '0;
    cpu_cs = 1'b1;
    cpu_wren = 1'b0;
    cpu_address = 8'h07;
    cpu_data = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_loading", 32'(loading), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_pass_addr", 32'(ram_address), 32'h07);
    chk("rst_pass_cs", 32'(ram_cs), 32'd1);
    chk("rst_pass_wren", 32'(ram_wren), 32'd0);
    cpu_cs = 1'b0;
    tick();

    // Four bytes back-to-back.
    stim_b = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_session("seq4", 1'b0, 1'b0);
    cpu_read(8'd0, rd);
    chk("seq4_ram0", 32'(rd), 32'h0201);
    cpu_read(8'd1, rd);
    chk("seq4_ram1", 32'(rd), 32'h0403);

    // Three bytes: partial word padded in FLUSH.
    stim_b = '{8'hAA, 8'hBB, 8'hCC};
    run_session("part3", 1'b0, 1'b0);
    chk("part3_cs_const", 32'(checksum), 32'h0231);
    cpu_read(8'd1, rd);
    chk("part3_ram1", 32'(rd), 32'hFFCC);

    // Overflow: 514 random bytes.
    stim_b.delete();
    for (int i = 0; i < CAP_BYTES + 2; i++) stim_b.push_back(8'($urandom));
    run_session("ovf", 1'b0, 1'b1);
    chk("ovf_wc_const", 32'(word_count), 32'd256);
    cpu_read(8'd255, rd);
    chk("ovf_ram255", 32'(rd), 32'(exp_mem[255]));

    // Reset after three bytes: word 0 written, word 1 never.
    ld0 = ld_cnt;
    exp_q.push_back('{addr: 8'd0, data: 16'h2211});
    exp_mem[0] = 16'h2211;
    ioctl_download = 1'b1;
    tick();
    ioctl_wr = 1'b1;
    ioctl_dout = 8'h11; tick();
    ioctl_dout = 8'h22; tick();
    ioctl_dout = 8'h33; tick();
    ioctl_wr = 1'b0;
    tick();
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    chk("rstmid_loading", 32'(loading), 32'd0);
    chk("rstmid_word_count", 32'(word_count), 32'd0);
    repeat (5) tick();
    chk("rstmid_no_done", 32'(ld_cnt - ld0), 32'd0);
    chk("rstmid_writes_left", 32'(exp_q.size()), 32'd0);

    // CPU write during LOAD ignored, then honoured in IDLE.
    ioctl_download = 1'b1;
    tick();
    cpu_cs = 1'b1;
    cpu_wren = 1'b1;
    cpu_address = 8'd5;
    cpu_data = 16'h5A3C;
    tick();
    chk("cpu_load_q", 32'(cpu_q), 32'hFFFF);
    chk("cpu_load_loading", 32'(loading), 32'd1);
    cpu_cs = 1'b0;
    cpu_wren = 1'b0;
    ioctl_download = 1'b0;
    wait_idle("cpu_load");
    tick();
    cpu_read(8'd5, rd);
    chk("cpu_load_ram5", 32'(rd), 32'(exp_mem[5]));
    exp_q.push_back('{addr: 8'd5, data: 16'h5A3C});
    exp_mem[5] = 16'h5A3C;
    cpu_cs = 1'b1;
    cpu_wren = 1'b1;
    tick();
    cpu_wren = 1'b0;
    cpu_cs = 1'b0;
    cpu_read(8'd5, rd);
    chk("cpu_idle_ram5", 32'(rd), 32'h5A3C);

    // Last strobe coincident with download falling.
    stim_b = '{8'h5A};
    run_session("coin1", 1'b1, 1'b0);
    cpu_read(8'd0, rd);
    chk("coin1_ram0", 32'(rd), 32'hFF5A);
    stim_b = '{8'h12, 8'h34};
    run_session("coin2", 1'b1, 1'b0);
    cpu_read(8'd0, rd);
    chk("coin2_ram0", 32'(rd), 32'h3412);

    // Randomized sessions.
    for (int s = 0; s < 8; s++) begin
      stim_b.delete();
      repeat ($urandom_range(1, 12)) stim_b.push_back(8'($urandom));
      run_session("rand", 1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
